sin_arbiter: RTL and testbench
==============================

SIN_ARBITER -- requirements
Module: sin_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one sin core (2..8).
REQ-002 Parameter TIMEOUT, 64, maximum cycles in WAIT before the transaction is aborted.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester request level, held until its ack.
REQ-006 req_x  input  NUM_REQ x 16  per-requester angle, Q1.15, stable while req high.
REQ-007 ack  output  NUM_REQ  one-cycle completion pulse, one-hot or zero.
REQ-008 rsp_data  output  16  sin result, Q1.15, valid when any ack bit high.
REQ-009 rsp_err  output  1  high with ack when the transaction timed out.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 owner  output  clog2(NUM_REQ)  index of the granted requester; 0 when idle.
REQ-012 sin_start  output  1  one-cycle start pulse to the sin core.
REQ-013 sin_x  output  16  angle to the sin core.
REQ-014 sin_result  input  16  sin core result, sampled only with sin_done.
REQ-015 sin_done  input  1  sin core completion flag.

Function
REQ-016 FSM states IDLE, START, WAIT, RESP; encoding is free.
REQ-017 IDLE: if any req bit is high, grant round-robin winner, latch owner and its req_x into sin_x, go START; else stay.
REQ-018 START: sin_start=1 for exactly this cycle, go WAIT; sin_done in START is ignored.
REQ-019 WAIT: on sin_done=1 register sin_result into rsp_data, rsp_err=0, go RESP.
REQ-020 WAIT: if TIMEOUT cycles elapse without sin_done, set rsp_data=0, rsp_err=1, go RESP.
REQ-021 RESP: ack[owner]=1 for exactly this cycle, go IDLE; rsp_data/rsp_err hold until the next RESP.
REQ-022 sin_x remains stable from START until RESP; it changes only on a new grant.
REQ-023 Round-robin: search starts at index (last granted + 1) mod NUM_REQ; after reset index 0 has highest priority.
REQ-024 Minimum latency: req sampled in IDLE at cycle 0, sin_start at cycle 1, ack at cycle (sin_done cycle + 1).
REQ-025 Withdrawn req before grant: not considered; after grant: transaction completes and ack is still pulsed.
REQ-026 req[owner] still high in the cycle after ack: treated as a new request, subject to round-robin.
REQ-027 sin_done in IDLE or RESP: ignored, no state change.
REQ-028 Timeout counter clears on every entry to WAIT; saturates, does not wrap.
REQ-029 Back-to-back: IDLE is visited for at least one cycle between transactions.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, ack=0, sin_start=0, sin_x=0, rsp_data=0, rsp_err=0, busy=0, owner=0, priority pointer=0, timeout counter=0.
REQ-031 Reset mid-transaction aborts it with no ack; late sin_done after reset is ignored per REQ-027.

Structure
REQ-032 Package sin_arb_pkg holds the state enum, Q1.15 width constant (16), and default NUM_REQ/TIMEOUT.
REQ-033 One sub-module rr_arbiter (req vector, pointer in; one-hot grant and index out, combinational) implements REQ-023.

Verification
REQ-034 Single: req=4'b0001, req_x[0]=16'h4000, core done after 5 cycles with 16'h3D5A -> sin_start at cycle 1, ack=4'b0001 with rsp_data=16'h3D5A, rsp_err=0.
REQ-035 Contention: req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each sin_x matches that requester's req_x.
REQ-036 Timeout: core never asserts done -> ack after TIMEOUT=64 WAIT cycles with rsp_err=1, rsp_data=0; next request proceeds normally.
REQ-037 Reset mid-WAIT: rst_n low for 1 cycle at WAIT cycle 2 -> no ack, all outputs at reset values, next grant goes to index 0 first.
REQ-038 Spurious done: sin_done pulsed in IDLE and in START -> no ack, no state change.
REQ-039 Withdraw: req[2] raised then dropped before grant while requester 1 is served -> requester 2 never acked.

Source files
------------

// File: rtl/sin_arb_pkg.sv
// Shared types and defaults for the round-robin sin-core arbiter.
package sin_arb_pkg;

    localparam int DATA_W      = 16;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/sin_arbiter_if.sv
// Requester side and sin-core side signals of the arbiter, bundled.
// Handshake: a requester holds req high (req_x stable) until its one-cycle ack pulse;
// sin_start is a one-cycle pulse, and sin_result is valid only in a cycle with sin_done high.
interface sin_arbiter_if
    import sin_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_x;
    logic [NUM_REQ-1:0]             ack;
    logic [DATA_W-1:0]              rsp_data;
    logic                           rsp_err;
    logic                           busy;
    logic [$clog2(NUM_REQ)-1:0]     owner;
    logic                           sin_start;
    logic [DATA_W-1:0]              sin_x;
    logic [DATA_W-1:0]              sin_result;
    logic                           sin_done;

    modport master (
        output req, req_x, sin_result, sin_done,
        input  ack, rsp_data, rsp_err, busy, owner, sin_start, sin_x
    );

    modport slave (
        input  req, req_x, sin_result, sin_done,
        output ack, rsp_data, rsp_err, busy, owner, sin_start, sin_x
    );
endinterface

// File: rtl/sin_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);
    always_comb begin
        logic found;
        int   p;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        p       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            p = int'(i_ptr) + i;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (!found && i_req[p]) begin
                found      = 1'b1;
                o_grant[p] = 1'b1;
                o_idx      = IDX_W'(p);
            end
        end
    end
endmodule

// File: rtl/sin_arbiter.sv
// Shares one sin core among NUM_REQ requesters: round-robin grant, start pulse,
// bounded wait for completion (timeout yields rsp_err), then a one-cycle ack.
module sin_arbiter
    import sin_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    sin_arbiter_if.slave  bus,
    output state_t        o_dbg_state
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_valid;
    logic [DATA_W-1:0]  r_sin_x;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_valid   = |w_grant;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (bus.sin_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_ptr      <= '0;
            r_sin_x    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_idx;
                        r_sin_x <= bus.req_x[w_idx];
                        r_ptr   <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                    end
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (bus.sin_done) begin
                        r_rsp_data <= bus.sin_result;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack       = (r_state == S_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    assign bus.sin_start = (r_state == S_START);
    assign bus.sin_x     = r_sin_x;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.owner     = (r_state == S_IDLE) ? '0 : r_owner;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_sin_arbiter.sv
// Directed bench for sin_arbiter: reset, single, contention, timeout, reset mid-WAIT,
// spurious done, and withdrawn request.
module tb_sin_arbiter;
    import sin_arb_pkg::*;

    localparam int N = 4;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     total;
    int     bad;

    sin_arbiter_if #(.NUM_REQ(N)) bus ();

    sin_arbiter #(.NUM_REQ(N), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        bus.sin_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for sin_start; cycles counts negedges from the call.
    task automatic wait_start(output bit ok, output logic [1:0] own,
                              output logic [15:0] x, output int cycles);
        ok = 1'b0; own = '0; x = '0; cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.sin_start) begin
                ok = 1'b1; own = bus.owner; x = bus.sin_x; cycles = i;
                break;
            end
        end
    endtask

    // Plays the sin core: done pulses at cycle 'delay' (0 = never); returns on ack.
    task automatic run_core(input int delay, input logic [15:0] data, output bit ok,
                            output logic [3:0] a, output logic [15:0] d,
                            output logic e, output int cycles);
        ok = 1'b0; a = '0; d = '0; e = 1'b0; cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.ack != 0) begin
                ok = 1'b1; a = bus.ack; d = bus.rsp_data; e = bus.rsp_err; cycles = i;
                break;
            end
            bus.sin_done   = (delay > 0) && (i == delay);
            bus.sin_result = data;
        end
        bus.sin_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.ack !== 4'b0) begin bad++; $display("FAIL reset_ack got=%b want=0000", bus.ack); end
        total++; if (bus.sin_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.sin_start); end
        total++; if (bus.sin_x !== 16'h0) begin bad++; $display("FAIL reset_sin_x got=%h want=0000", bus.sin_x); end
        total++; if (bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b want=0000/0", bus.rsp_data, bus.rsp_err); end
        total++; if (bus.owner !== 2'd0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", bus.owner, dbg_state); end
    endtask

    task automatic test_single();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        bus.req_x[0] = 16'h4000;
        bus.req = 4'b0001;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || cyc != 1) begin bad++; $display("FAIL single_start_latency got=%0d want=1", cyc); end
        total++; if (own !== 2'd0 || x !== 16'h4000) begin bad++; $display("FAIL single_grant got=%0d/%h want=0/4000", own, x); end
        run_core(5, 16'h3D5A, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || cyc != 6) begin bad++; $display("FAIL single_ack_latency got=%0d want=6", cyc); end
        total++; if (a !== 4'b0001 || d !== 16'h3D5A || e !== 1'b0) begin bad++; $display("FAIL single_rsp got=%b/%h/%b want=0001/3d5a/0", a, d, e); end
        total++; if (bus.sin_x !== 16'h4000) begin bad++; $display("FAIL single_sin_x_stable got=%h want=4000", bus.sin_x); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.rsp_data !== 16'h3D5A) begin bad++; $display("FAIL single_after got=%b/%b/%h want=0/0000/3d5a", bus.busy, bus.ack, bus.rsp_data); end
    endtask

    task automatic test_contention();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        logic [1:0] exp_own;
        logic [15:0] xs [4];
        xs[0] = 16'h1111; xs[1] = 16'h2222; xs[2] = 16'h3333; xs[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < N; i++) bus.req_x[i] = xs[i];
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_own = 2'(k % 4);
            wait_start(ok, own, x, cyc);
            total++; if (!ok || own !== exp_own || x !== xs[exp_own]) begin bad++; $display("FAIL contention_grant k=%0d got=%0d/%h want=%0d/%h", k, own, x, exp_own, xs[exp_own]); end
            run_core(2, 16'h0100 + 16'(k), ok, a, d, e, cyc);
            if (k == 4) bus.req = 4'b0000;
            total++; if (!ok || a !== (4'b0001 << exp_own) || d !== 16'h0100 + 16'(k)) begin bad++; $display("FAIL contention_ack k=%0d got=%b/%h want=%b/%h", k, a, d, 4'b0001 << exp_own, 16'h0100 + 16'(k)); end
            @(negedge clk);
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL contention_idle_gap k=%0d got=%b want=0", k, bus.busy); end
        end
    endtask

    task automatic test_timeout();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        bus.req_x[0] = 16'h0AAA;
        bus.req = 4'b0001;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || own !== 2'd0) begin bad++; $display("FAIL timeout_grant got=%0d want=0", own); end
        run_core(0, 16'h0000, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || cyc != 65) begin bad++; $display("FAIL timeout_latency got=%0d want=65", cyc); end
        total++; if (a !== 4'b0001 || d !== 16'h0 || e !== 1'b1) begin bad++; $display("FAIL timeout_rsp got=%b/%h/%b want=0001/0000/1", a, d, e); end
        @(negedge clk);
        bus.req_x[1] = 16'h1234;
        bus.req = 4'b0010;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || own !== 2'd1 || x !== 16'h1234) begin bad++; $display("FAIL timeout_next_grant got=%0d/%h want=1/1234", own, x); end
        run_core(3, 16'h5A5A, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || a !== 4'b0010 || d !== 16'h5A5A || e !== 1'b0 || cyc != 4) begin bad++; $display("FAIL timeout_next_rsp got=%b/%h/%b/%0d want=0010/5a5a/0/4", a, d, e, cyc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        int acks;
        bus.req_x[2] = 16'h7777;
        bus.req = 4'b0100;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || own !== 2'd2) begin bad++; $display("FAIL rstwait_grant got=%0d want=2", own); end
        repeat (2) @(negedge clk);
        total++; if (dbg_state !== S_WAIT) begin bad++; $display("FAIL rstwait_in_wait got=%0d want=%0d", dbg_state, S_WAIT); end
        rst_n = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.sin_start !== 1'b0 || bus.owner !== 2'd0) begin bad++; $display("FAIL rstwait_ctrl got=%b/%b/%b/%0d want=0/0000/0/0", bus.busy, bus.ack, bus.sin_start, bus.owner); end
        total++; if (bus.sin_x !== 16'h0 || bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rstwait_data got=%h/%h/%b want=0000/0000/0", bus.sin_x, bus.rsp_data, bus.rsp_err); end
        bus.sin_done = 1'b1;
        bus.sin_result = 16'hBEEF;
        @(negedge clk);
        bus.sin_done = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack != 0 || bus.busy) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL rstwait_late_done got=%0d want=0", acks); end
        for (int i = 0; i < N; i++) bus.req_x[i] = 16'h0800 + 16'(i);
        bus.req = 4'b1111;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || own !== 2'd0 || x !== 16'h0800) begin bad++; $display("FAIL rstwait_first_grant got=%0d/%h want=0/0800", own, x); end
        run_core(1, 16'h0042, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || a !== 4'b0001 || d !== 16'h0042) begin bad++; $display("FAIL rstwait_first_rsp got=%b/%h want=0001/0042", a, d); end
        @(negedge clk);
    endtask

    task automatic test_spurious_done();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        bus.sin_done = 1'b1;
        bus.sin_result = 16'hDEAD;
        @(negedge clk);
        bus.sin_done = 1'b0;
        total++; if (dbg_state !== S_IDLE || bus.ack !== 4'b0 || bus.rsp_data !== 16'h0042) begin bad++; $display("FAIL spur_idle got=%0d/%b/%h want=0/0000/0042", dbg_state, bus.ack, bus.rsp_data); end
        bus.req_x[0] = 16'h0123;
        bus.req = 4'b0001;
        wait_start(ok, own, x, cyc);
        bus.sin_done = 1'b1;
        bus.sin_result = 16'hDEAD;
        @(negedge clk);
        bus.sin_done = 1'b0;
        total++; if (dbg_state !== S_WAIT || bus.ack !== 4'b0) begin bad++; $display("FAIL spur_start got=%0d/%b want=%0d/0000", dbg_state, bus.ack, S_WAIT); end
        run_core(3, 16'h0321, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || a !== 4'b0001 || d !== 16'h0321 || cyc != 4) begin bad++; $display("FAIL spur_rsp got=%b/%h/%0d want=0001/0321/4", a, d, cyc); end
        bus.sin_done = 1'b1;
        bus.sin_result = 16'hDEAD;
        @(negedge clk);
        bus.sin_done = 1'b0;
        total++; if (dbg_state !== S_IDLE || bus.rsp_data !== 16'h0321) begin bad++; $display("FAIL spur_resp got=%0d/%h want=0/0321", dbg_state, bus.rsp_data); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin bad++; $display("FAIL spur_after got=%b/%b want=0/0000", bus.busy, bus.ack); end
    endtask

    task automatic test_withdraw();
        bit ok; logic [1:0] own; logic [15:0] x, d; logic [3:0] a; logic e; int cyc;
        int stray;
        do_reset();
        bus.req_x[1] = 16'h1010;
        bus.req_x[2] = 16'h2020;
        bus.req = 4'b0010;
        wait_start(ok, own, x, cyc);
        total++; if (!ok || own !== 2'd1) begin bad++; $display("FAIL withdraw_grant got=%0d want=1", own); end
        @(negedge clk);
        bus.req[2] = 1'b1;
        @(negedge clk);
        bus.req[2] = 1'b0;
        run_core(2, 16'h0777, ok, a, d, e, cyc);
        bus.req = 4'b0000;
        total++; if (!ok || a !== 4'b0010 || d !== 16'h0777) begin bad++; $display("FAIL withdraw_rsp got=%b/%h want=0010/0777", a, d); end
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ack[2] || bus.busy) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL withdraw_no_ack got=%0d want=0", stray); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_x = '0;
        bus.sin_done = 1'b0;
        bus.sin_result = '0;
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        test_spurious_done();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
